// File: rtl/rfu_pkg.sv
// Shared types for the register-file write arbiter.
// Grant sources, debug FSM states and RF address width.
package rfu_pkg;

  localparam int RF_ADDR_LEN = 5;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_LATE,
    GNT_DBG
  } gnt_e;

  typedef enum logic {
    DBG_IDLE,
    DBG_PEND
  } dbg_st_e;

endpackage

// File: rtl/rfu_late_fifo.sv
// Late-result FIFO with per-entry destination compare.
// DEPTH must be a power of two so the pointers wrap naturally.
import rfu_pkg::*;

module rfu_late_fifo #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [RF_ADDR_LEN-1:0] push_addr,
  input  logic [XLEN-1:0]        push_data,
  input  logic                   push_len,
  input  logic                   pop,
  input  logic [RF_ADDR_LEN-1:0] rs1_addr,
  input  logic [RF_ADDR_LEN-1:0] rs2_addr,
  output logic                   full,
  output logic                   empty,
  output logic [RF_ADDR_LEN-1:0] head_addr,
  output logic [XLEN-1:0]        head_data,
  output logic                   head_len,
  output logic                   rs1_hit,
  output logic                   rs2_hit
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]          wptr;
  logic [PW-1:0]          rptr;
  logic [DEPTH-1:0]       vld;
  logic [DEPTH-1:0]       vld_nx;
  logic [RF_ADDR_LEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0]        data_q [DEPTH];
  logic [DEPTH-1:0]       len_q;
  logic                   do_push;
  logic                   do_pop;

  assign full    = &vld;
  assign empty   = ~|vld;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    vld_nx = vld;
    if (do_pop)  vld_nx[rptr] = 1'b0;
    if (do_push) vld_nx[wptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      vld <= vld_nx;
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Payload needs no reset: vld qualifies every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wptr] <= push_addr;
      data_q[wptr] <= push_data;
      len_q[wptr]  <= push_len;
    end
  end

  assign head_addr = addr_q[rptr];
  assign head_data = data_q[rptr];
  assign head_len  = len_q[rptr];

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && addr_q[i] == rs1_addr && rs1_addr != '0)
        rs1_hit = 1'b1;
      if (vld[i] && addr_q[i] == rs2_addr && rs2_addr != '0)
        rs2_hit = 1'b1;
    end
  end

endmodule

// File: rtl/rfu_wr_arb.sv
// Register-file write-port arbiter: WB > late FIFO > debug.
// Define RFU_ARB_STARVE_EN for the FIFO-head starvation stall.
import rfu_pkg::*;

module rfu_wr_arb #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wb_wr,
  input  logic [RF_ADDR_LEN-1:0] wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   wb_len_64,
  input  logic                   late_valid,
  output logic                   late_ready,
  input  logic [RF_ADDR_LEN-1:0] late_addr,
  input  logic [XLEN-1:0]        late_data,
  input  logic                   late_len_64,
  input  logic                   halted,
  input  logic                   dbg_gpr_wr,
  input  logic [RF_ADDR_LEN-1:0] dbg_addr,
  input  logic [31:0]            dbg_wdata,
  output logic                   dbg_done,
  output logic                   dbg_abort,
  input  logic [RF_ADDR_LEN-1:0] rs1_addr,
  input  logic [RF_ADDR_LEN-1:0] rs2_addr,
  output logic                   rs1_hazard,
  output logic                   rs2_hazard,
  output logic                   stall_req,
  output logic                   rf_wen,
  output logic [RF_ADDR_LEN-1:0] rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic                   rf_len_64
);

  localparam logic [2:0] AGE_TH = 3'(STARVE_LIMIT - 1);

  logic                   f_full;
  logic                   f_empty;
  logic [RF_ADDR_LEN-1:0] f_addr;
  logic [XLEN-1:0]        f_data;
  logic                   f_len;
  logic                   deq;
  logic                   enq;

  gnt_e                   gnt;
  logic                   req_wb;
  logic                   req_late;
  logic                   req_dbg;

  dbg_st_e                st;
  dbg_st_e                st_nx;
  logic                   dbg_req;
  logic                   dbg_drop;
  logic                   dbg_cap;
  logic [RF_ADDR_LEN-1:0] dbg_addr_q;
  logic [31:0]            dbg_data_q;
  logic                   done_q;
  logic                   abort_q;

  assign late_ready = !f_full;
  assign enq        = late_valid && !f_full;
  assign deq        = (gnt == GNT_LATE);

  rfu_late_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (enq),
    .push_addr (late_addr),
    .push_data (late_data),
    .push_len  (late_len_64),
    .pop       (deq),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .full      (f_full),
    .empty     (f_empty),
    .head_addr (f_addr),
    .head_data (f_data),
    .head_len  (f_len),
    .rs1_hit   (rs1_hazard),
    .rs2_hit   (rs2_hazard)
  );

  // One-hot requests keep the priority decode unique.
  assign req_wb   = wb_wr;
  assign req_late = !wb_wr && !f_empty;
  assign req_dbg  = !wb_wr && f_empty && dbg_req;

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      req_wb:   gnt = GNT_WB;
      req_late: gnt = GNT_LATE;
      req_dbg:  gnt = GNT_DBG;
      default:  gnt = GNT_NONE;
    endcase
  end

  always_comb begin
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_len_64 = 1'b0;
    unique case (gnt)
      GNT_WB: begin
        rf_waddr  = wb_addr;
        rf_wdata  = wb_data;
        rf_len_64 = wb_len_64;
      end
      GNT_LATE: begin
        rf_waddr  = f_addr;
        rf_wdata  = f_data;
        rf_len_64 = f_len;
      end
      GNT_DBG: begin
        rf_waddr  = dbg_addr_q;
        rf_wdata  = {{(XLEN-32){1'b0}}, dbg_data_q};
        rf_len_64 = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 writes are consumed but never reach the file.
  assign rf_wen = (gnt != GNT_NONE) && (rf_waddr != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= DBG_IDLE;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      DBG_IDLE: if (dbg_gpr_wr && halted) st_nx = DBG_PEND;
      DBG_PEND: if (dbg_drop || gnt == GNT_DBG) st_nx = DBG_IDLE;
      default:  st_nx = DBG_IDLE;
    endcase
  end

  always_comb begin
    dbg_req  = (st == DBG_PEND) && halted;
    dbg_drop = (st == DBG_PEND) && !halted;
    dbg_cap  = (st == DBG_IDLE) && dbg_gpr_wr && halted;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_addr_q <= '0;
      dbg_data_q <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      if (dbg_cap) begin
        dbg_addr_q <= dbg_addr;
        dbg_data_q <= dbg_wdata;
      end
      done_q  <= (gnt == GNT_DBG);
      abort_q <= dbg_drop;
    end
  end

  assign dbg_done  = done_q;
  assign dbg_abort = abort_q;

`ifdef RFU_ARB_STARVE_EN
  logic [2:0] age;
  logic       stall_q;
  logic       lost;

  assign lost = !f_empty && wb_wr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      age     <= '0;
      stall_q <= 1'b0;
    end else begin
      if (deq || f_empty)
        age <= '0;
      else if (lost && age != 3'd7)
        age <= age + 3'd1;
      if (deq)
        stall_q <= 1'b0;
      else if (lost && age >= AGE_TH)
        stall_q <= 1'b1;
    end
  end

  assign stall_req = stall_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^AGE_TH;
  assign stall_req  = 1'b0;
`endif

endmodule
